// File: rtl/msk_aes_core_sequencer_pkg.sv
// Shared definitions for the MSK AES core sequencer: FSM encodings, key-size
// codes, command/cache payloads and the key-cache miss rule.
package msk_aes_core_sequencer_pkg;

  localparam int unsigned ST_W      = 3;
  localparam int unsigned KSIZE_W   = 2;
  localparam int unsigned RST_CNT_W = 4;
  localparam int unsigned PERF_W    = 32;

  localparam logic [ST_W-1:0] S_RST     = 3'd0;
  localparam logic [ST_W-1:0] S_IDLE    = 3'd1;
  localparam logic [ST_W-1:0] S_KS_REQ  = 3'd2;
  localparam logic [ST_W-1:0] S_KS_WAIT = 3'd3;
  localparam logic [ST_W-1:0] S_OP_REQ  = 3'd4;
  localparam logic [ST_W-1:0] S_OP_WAIT = 3'd5;
  localparam logic [ST_W-1:0] S_ERR     = 3'd6;

  localparam logic [KSIZE_W-1:0] KSIZE_128  = 2'd0;
  localparam logic [KSIZE_W-1:0] KSIZE_192  = 2'd1;
  localparam logic [KSIZE_W-1:0] KSIZE_256  = 2'd2;
  localparam logic [KSIZE_W-1:0] KSIZE_RSVD = 2'd3;

  typedef struct packed {
    logic               inverse;
    logic [KSIZE_W-1:0] ksize;
  } seq_cmd_t;

  typedef struct packed {
    logic               valid;
    logic [KSIZE_W-1:0] ksize;
  } key_cache_t;

  // The core's cached last round key is reusable only for the same key and size.
  function automatic logic cache_miss(key_cache_t c, logic rekey, logic [KSIZE_W-1:0] ksize);
    return !c.valid || rekey || (ksize != c.ksize);
  endfunction

endpackage

// File: rtl/msk_aes_core_sequencer_if.sv
// Host command, result handshake and core control signals of the sequencer.
// slave = sequencer view; master = host plus core view.
interface msk_aes_core_sequencer_if;
  logic       flush;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_inverse;
  logic [1:0] cmd_ksize;
  logic       cmd_rekey;
  logic       out_valid;
  logic       out_ready;
  logic       core_rst;
  logic       core_valid_in;
  logic       core_in_ready;
  logic       core_inverse;
  logic       core_ksonly;
  logic       core_mode256;
  logic       core_mode192;
  logic       core_last_key_pv;
  logic       core_cipher_valid;
  logic       core_out_ready;

  modport slave (
    input  flush, cmd_valid, cmd_inverse, cmd_ksize, cmd_rekey, out_ready,
           core_in_ready, core_last_key_pv, core_cipher_valid,
    output cmd_ready, out_valid, core_rst, core_valid_in, core_inverse,
           core_ksonly, core_mode256, core_mode192, core_out_ready
  );

  modport master (
    output flush, cmd_valid, cmd_inverse, cmd_ksize, cmd_rekey, out_ready,
           core_in_ready, core_last_key_pv, core_cipher_valid,
    input  cmd_ready, out_valid, core_rst, core_valid_in, core_inverse,
           core_ksonly, core_mode256, core_mode192, core_out_ready
  );
endinterface

// File: rtl/msk_aes_seq_rstgen.sv
// Core reset generator: holds core_rst high for RST_CYCLES clocks after rst_n
// release or a flush pulse, using a 4-bit down-counter.
module msk_aes_seq_rstgen
  import msk_aes_core_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  output logic core_rst_o,
  output logic last_o
);

  localparam logic [RST_CNT_W-1:0] LOAD = RST_CNT_W'(RST_CYCLES);

  logic [RST_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - RST_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign core_rst_o = (cnt_q != '0);
  // Final reset cycle: the sequencer leaves RST on the same edge core_rst drops.
  assign last_o     = (cnt_q == RST_CNT_W'(1));

endmodule

// File: rtl/msk_aes_core_sequencer.sv
// Command-level controller for MSKaes_32bits_core: runs encrypt/decrypt commands,
// inserts a key-schedule pass on decrypt cache miss. Option: MSK_AES_SEQ_PERF_EN.
module msk_aes_core_sequencer
  import msk_aes_core_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  msk_aes_core_sequencer_if.slave      sif
`ifdef MSK_AES_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_blocks,
  output logic [PERF_W-1:0]            perf_ks
`endif
);

  logic core_rst;
  logic rst_last;

  msk_aes_seq_rstgen #(.RST_CYCLES(RST_CYCLES)) u_rstgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (sif.flush),
    .core_rst_o(core_rst),
    .last_o    (rst_last)
  );

  logic [ST_W-1:0] state_q, state_d;
  seq_cmd_t        cmd_q, cmd_d;
  key_cache_t      cache_q, cache_d;
  logic            mode256_q, mode256_d;
  logic            mode192_q, mode192_d;

  logic valid_in_c, ksonly_c, inverse_c, cmd_ready_c, out_valid_c, out_ready_c;

  // Next-state and control outputs; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cache_d     = cache_q;
    mode256_d   = mode256_q;
    mode192_d   = mode192_q;
    valid_in_c  = 1'b0;
    ksonly_c    = 1'b0;
    inverse_c   = 1'b0;
    cmd_ready_c = 1'b0;
    out_valid_c = 1'b0;
    out_ready_c = 1'b0;

    case (state_q)
      S_RST: begin
        if (rst_last) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (sif.cmd_valid) begin
          cmd_d.inverse = sif.cmd_inverse;
          cmd_d.ksize   = sif.cmd_ksize;
          if (sif.cmd_ksize == KSIZE_RSVD) begin
            state_d = S_ERR;
          end else begin
            mode256_d = (sif.cmd_ksize == KSIZE_256);
            mode192_d = (sif.cmd_ksize == KSIZE_192);
            if (sif.cmd_inverse && cache_miss(cache_q, sif.cmd_rekey, sif.cmd_ksize)) begin
              state_d = S_KS_REQ;
            end else begin
              state_d = S_OP_REQ;
            end
            // An encrypt with a new key leaves the core's last round key stale.
            if (!sif.cmd_inverse && sif.cmd_rekey) cache_d.valid = 1'b0;
          end
        end
      end
      S_KS_REQ: begin
        valid_in_c = 1'b1;
        ksonly_c   = 1'b1;
        if (sif.core_in_ready) state_d = S_KS_WAIT;
      end
      S_KS_WAIT: begin
        if (sif.core_last_key_pv) begin
          cache_d.valid = 1'b1;
          cache_d.ksize = cmd_q.ksize;
          state_d       = S_OP_REQ;
        end
      end
      S_OP_REQ: begin
        valid_in_c  = 1'b1;
        inverse_c   = cmd_q.inverse;
        cmd_ready_c = sif.core_in_ready;
        if (sif.core_in_ready) state_d = S_OP_WAIT;
      end
      S_OP_WAIT: begin
        out_valid_c = sif.core_cipher_valid;
        out_ready_c = sif.out_ready;
        if (sif.core_cipher_valid && sif.out_ready) state_d = S_IDLE;
      end
      S_ERR: begin
        cmd_ready_c = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sif.flush) begin
      state_d     = S_RST;
      cache_d     = '0;
      mode256_d   = 1'b0;
      mode192_d   = 1'b0;
      cmd_ready_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      cmd_q     <= '0;
      cache_q   <= '0;
      mode256_q <= 1'b0;
      mode192_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cache_q   <= cache_d;
      mode256_q <= mode256_d;
      mode192_q <= mode192_d;
    end
  end

  assign sif.core_rst       = core_rst;
  assign sif.core_valid_in  = valid_in_c;
  assign sif.core_ksonly    = ksonly_c;
  assign sif.core_inverse   = inverse_c;
  assign sif.core_mode256   = mode256_q;
  assign sif.core_mode192   = mode192_q;
  assign sif.cmd_ready      = cmd_ready_c;
  assign sif.out_valid      = out_valid_c;
  assign sif.core_out_ready = out_ready_c;

`ifdef MSK_AES_SEQ_PERF_EN
  logic              blk_done_c, ks_done_c;
  logic [PERF_W-1:0] perf_blocks_q, perf_ks_q;

  assign blk_done_c = (state_q == S_OP_WAIT) && sif.core_cipher_valid && sif.out_ready;
  assign ks_done_c  = (state_q == S_KS_WAIT) && sif.core_last_key_pv;

  // Wrapping event counters, cleared together with the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_blocks_q <= '0;
      perf_ks_q     <= '0;
    end else if (sif.flush) begin
      perf_blocks_q <= '0;
      perf_ks_q     <= '0;
    end else begin
      if (blk_done_c) perf_blocks_q <= perf_blocks_q + PERF_W'(1);
      if (ks_done_c)  perf_ks_q     <= perf_ks_q + PERF_W'(1);
    end
  end

  assign perf_blocks = perf_blocks_q;
  assign perf_ks     = perf_ks_q;
`endif

endmodule
